// File: rtl/nor_cmd_sequencer.sv
// Expands one user operation into timed command-write and read cycles on a
// 16-bit parallel NOR flash bus; all bus outputs are registered.
//
// state    | meaning
// IDLE     | waiting for a request, req_ready high
// W_SETUP  | ce_n low, address and data driven, we_n still high
// W_PULSE  | we_n low for T_WE clocks
// W_HOLD   | we_n high again, data still driven
// R_ACC    | ce_n and oe_n low for T_RD clocks, dq sampled on the last edge
// RECOV    | ce_n high for T_REC clocks, then pick the next step
// DONE     | rsp_valid pulse
module nor_cmd_sequencer #(
  parameter int T_WE     = 2,
  parameter int T_RD     = 4,
  parameter int T_REC    = 2,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        nor_ce_n,
  output logic        nor_we_n,
  output logic        nor_oe_n,
  output logic [23:0] nor_addr,
  output logic [15:0] nor_dq_o,
  output logic        nor_dq_oe,
  input  logic [15:0] nor_dq_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WSETUP = 3'd1;
  localparam logic [2:0] S_WPULSE = 3'd2;
  localparam logic [2:0] S_WHOLD  = 3'd3;
  localparam logic [2:0] S_RACC   = 3'd4;
  localparam logic [2:0] S_RECOV  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_STATUS  = 2'd1;
  localparam logic [1:0] OP_PROGRAM = 2'd2;
  localparam logic [1:0] OP_UNLOCK  = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  step_q, step_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] poll_q, poll_d;
  logic [15:0] rd_q, rd_d;
  logic        tmo_q, tmo_d;

  // Step programs: PROGRAM = 0x40, wdata, poll (step 2, repeats), 0x50, 0xFF.
  function automatic logic step_is_read(input logic [1:0] op, input logic [2:0] step);
    case (op)
      OP_PROGRAM: return step == 3'd2;
      OP_UNLOCK:  return 1'b0;
      default:    return step == 3'd1;
    endcase
  endfunction

  function automatic logic step_is_last(input logic [1:0] op, input logic [2:0] step);
    if (op == OP_PROGRAM) return step == 3'd4;
    return step == 3'd1;
  endfunction

  function automatic logic [15:0] cmd_word(input logic [1:0] op, input logic [2:0] step,
                                           input logic [15:0] wdata);
    case (op)
      OP_READ:   return 16'h00FF;
      OP_STATUS: return 16'h0070;
      OP_UNLOCK: return (step == 3'd0) ? 16'h0060 : 16'h00D0;
      default: begin
        case (step)
          3'd0:    return 16'h0040;
          3'd1:    return wdata;
          3'd3:    return 16'h0050;
          default: return 16'h00FF;
        endcase
      end
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    op_d    = op_q;
    step_d  = step_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    poll_d  = poll_q;
    rd_d    = rd_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          step_d  = 3'd0;
          poll_d  = 16'd0;
          tmo_d   = 1'b0;
          state_d = S_WSETUP;
        end
      end
      S_WSETUP: begin
        state_d = S_WPULSE;
        tmr_d   = 8'(T_WE - 1);
      end
      S_WPULSE: begin
        if (tmr_q == 8'd0) state_d = S_WHOLD;
        else               tmr_d   = tmr_q - 8'd1;
      end
      S_WHOLD: begin
        state_d = S_RECOV;
        tmr_d   = 8'(T_REC - 1);
      end
      S_RACC: begin
        if (tmr_q == 8'd0) begin
          rd_d    = nor_dq_i;
          poll_d  = poll_q + 16'd1;
          state_d = S_RECOV;
          tmr_d   = 8'(T_REC - 1);
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_RECOV: begin
        if (tmr_q != 8'd0) begin
          tmr_d = tmr_q - 8'd1;
        end else if (step_is_last(op_q, step_q)) begin
          state_d = S_DONE;
        end else begin
          // Poll step repeats until SR[7] or the poll budget runs out.
          if (op_q == OP_PROGRAM && step_q == 3'd2) begin
            if (rd_q[7] || poll_q == 16'(POLL_MAX)) begin
              step_d = 3'd3;
              tmo_d  = ~rd_q[7];
            end
          end else begin
            step_d = step_q + 3'd1;
          end
          if (step_is_read(op_q, step_d)) begin
            state_d = S_RACC;
            tmr_d   = 8'(T_RD - 1);
          end else begin
            state_d = S_WSETUP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= 8'd0;
      op_q      <= OP_READ;
      step_q    <= 3'd0;
      addr_q    <= 24'd0;
      wdata_q   <= 16'd0;
      poll_q    <= 16'd0;
      rd_q      <= 16'd0;
      tmo_q     <= 1'b0;
      nor_ce_n  <= 1'b1;
      nor_we_n  <= 1'b1;
      nor_oe_n  <= 1'b1;
      nor_dq_oe <= 1'b0;
      nor_addr  <= 24'd0;
      nor_dq_o  <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      op_q      <= op_d;
      step_q    <= step_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      poll_q    <= poll_d;
      rd_q      <= rd_d;
      tmo_q     <= tmo_d;
      // Bus pins are registered from the next state so the pads never glitch.
      nor_ce_n  <= !(state_d inside {S_WSETUP, S_WPULSE, S_WHOLD, S_RACC});
      nor_we_n  <= (state_d != S_WPULSE);
      nor_oe_n  <= (state_d != S_RACC);
      nor_dq_oe <= (state_d inside {S_WSETUP, S_WPULSE, S_WHOLD});
      nor_addr  <= addr_d;
      if (state_d == S_WSETUP) nor_dq_o <= cmd_word(op_d, step_d, wdata_d);
      rsp_valid <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        rsp_data <= (op_q == OP_UNLOCK) ? 16'd0 : rd_q;
        rsp_err  <= (op_q == OP_PROGRAM) & (tmo_q | rd_q[4] | rd_q[3] | rd_q[1]);
      end
    end
  end

endmodule

// File: tb/tb_nor_cmd_sequencer.sv
// Bench for nor_cmd_sequencer: a scripted flash model on the bus, a per-cycle
// expected bus waveform built from the operation step lists, and random operations.
module tb_nor_cmd_sequencer;

  localparam int T_WE = 2, T_RD = 4, T_REC = 2, PMAX = 8;
  localparam logic [15:0] BUSY_SR = 16'h0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [23:0] req_addr = 24'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        nor_ce_n, nor_we_n, nor_oe_n, nor_dq_oe;
  logic [23:0] nor_addr;
  logic [15:0] nor_dq_o, nor_dq_i;

  always #5 clk = ~clk;

  nor_cmd_sequencer #(.T_WE(T_WE), .T_RD(T_RD), .T_REC(T_REC), .POLL_MAX(PMAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .nor_ce_n(nor_ce_n), .nor_we_n(nor_we_n), .nor_oe_n(nor_oe_n), .nor_addr(nor_addr),
    .nor_dq_o(nor_dq_o), .nor_dq_oe(nor_dq_oe), .nor_dq_i(nor_dq_i)
  );

  // Flash model: array/status read mode, program busy for fl_left status reads.
  int          fl_busy_cfg = 0;
  logic [15:0] fl_sr = 16'h0080;
  logic [15:0] fl_word = 16'h0000;
  int          gen = 0;
  int          gen_seen = 0;
  logic        fl_mode = 1'b0;
  logic        fl_pend = 1'b0;
  int          fl_left = 0;
  logic        we_prev = 1'b1, oe_prev = 1'b1;
  logic [15:0] wr_log[$];
  int          rd_cnt = 0;

  assign nor_dq_i = nor_oe_n ? 16'hBEEF : (fl_mode ? ((fl_left > 0) ? BUSY_SR : fl_sr) : fl_word);

  always @(negedge clk) begin
    if (gen != gen_seen) begin
      gen_seen = gen;
      wr_log.delete();
      rd_cnt  = 0;
      fl_left = fl_busy_cfg;
    end
    if (!we_prev && nor_we_n) begin
      wr_log.push_back(nor_dq_o);
      if (fl_pend) begin
        fl_pend = 1'b0;
        fl_mode = 1'b1;
      end else if (nor_dq_o == 16'h00FF) fl_mode = 1'b0;
      else if (nor_dq_o == 16'h0070) fl_mode = 1'b1;
      else if (nor_dq_o == 16'h0040) fl_pend = 1'b1;
    end
    if (!oe_prev && nor_oe_n) begin
      rd_cnt++;
      if (fl_left > 0) fl_left--;
    end
    if (reset) begin
      fl_mode = 1'b0;
      fl_pend = 1'b0;
    end
    we_prev = nor_we_n;
    oe_prev = nor_oe_n;
  end

  typedef struct {
    logic        ce_n, we_n, oe_n, dq_oe, rv, rerr;
    logic [15:0] dq, rdata;
    logic [23:0] addr;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t ce;
  int   checks = 0, errors = 0;
  int   cyc = 0, hs_cyc = 0, rsp_cyc = 0;
  logic track = 1'b0, chk_en = 1'b0;
  logic [15:0] got_data;
  logic        got_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic cyc_t mk(input logic c, input logic w, input logic o, input logic doe,
                              input logic [15:0] d, input logic [23:0] a);
    cyc_t e;
    e.ce_n = c; e.we_n = w; e.oe_n = o; e.dq_oe = doe; e.dq = d; e.addr = a;
    e.rv = 1'b0; e.rdata = 16'd0; e.rerr = 1'b0;
    return e;
  endfunction

  task automatic m_write(input logic [23:0] a, input logic [15:0] d);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, d, a));
    repeat (T_WE) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, d, a));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, d, a));
    repeat (T_REC) exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, d, a));
  endtask

  task automatic m_read(input logic [23:0] a);
    repeat (T_RD) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, a));
    repeat (T_REC) exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'd0, a));
  endtask

  task automatic build(input logic [1:0] op, input logic [23:0] a, input logic [15:0] wd,
                       input int bsy, input logic [15:0] sr, input logic [15:0] word);
    cyc_t e;
    logic [15:0] xd;
    logic xe;
    int nrd;
    exp_q.delete();
    xd = 16'd0; xe = 1'b0;
    case (op)
      2'd0: begin m_write(a, 16'h00FF); m_read(a); xd = word; end
      2'd1: begin m_write(a, 16'h0070); m_read(a); xd = sr; end
      2'd2: begin
        nrd = (bsy + 1 <= PMAX) ? bsy + 1 : PMAX;
        m_write(a, 16'h0040); m_write(a, wd);
        repeat (nrd) m_read(a);
        m_write(a, 16'h0050); m_write(a, 16'h00FF);
        if (bsy + 1 <= PMAX) begin xd = sr; xe = sr[4] | sr[3] | sr[1]; end
        else begin xd = BUSY_SR; xe = 1'b1; end
      end
      default: begin m_write(a, 16'h0060); m_write(a, 16'h00D0); end
    endcase
    e = mk(1'b1, 1'b1, 1'b1, 1'b0, 16'd0, a);
    e.rv = 1'b1; e.rdata = xd; e.rerr = xe;
    exp_q.push_back(e);
    fl_busy_cfg = bsy; fl_sr = sr; fl_word = word;
    gen++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [15:0] wd);
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 24'($urandom); req_wdata = 16'($urandom);
    track = 1'b1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [23:0] a, input logic [15:0] wd,
                        input int bsy, input logic [15:0] sr, input logic [15:0] word);
    int b;
    build(op, a, wd, bsy, sr, word);
    issue(op, a, wd);
    b = 300;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    chk("op_complete", 32'(exp_q.size()), 0);
    if (exp_q.size() != 0) begin
      track = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("bus_safety", 32'({nor_dq_oe & ~nor_oe_n, ~nor_we_n & ~nor_oe_n}), 0);
          if (track && exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("bus", 32'({nor_ce_n, nor_we_n, nor_oe_n, nor_dq_oe, rsp_valid, req_ready, busy}),
                32'({ce.ce_n, ce.we_n, ce.oe_n, ce.dq_oe, ce.rv, 1'b0, 1'b1}));
            if (!ce.ce_n) chk("addr", 32'(nor_addr), 32'(ce.addr));
            if (ce.dq_oe) chk("dq_o", 32'(nor_dq_o), 32'(ce.dq));
            if (ce.rv) begin
              chk("rsp", 32'({rsp_err, rsp_data}), 32'({ce.rerr, ce.rdata}));
              got_data = rsp_data;
              got_err  = rsp_err;
              rsp_cyc  = cyc;
            end
            if (exp_q.size() == 0) track = 1'b0;
          end else begin
            chk("idle", 32'({nor_ce_n, nor_we_n, nor_oe_n, nor_dq_oe, rsp_valid, req_ready, busy}),
                32'(7'b1110_010));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", 32'({nor_ce_n, nor_we_n, nor_oe_n, nor_dq_oe, req_ready}), 32'(5'b11101));
    chk("reset_addr_dq", 32'({nor_addr, nor_dq_o[7:0]}), 0);
    chk("reset_dq_hi", 32'(nor_dq_o), 0);
    chk("reset_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op(2'd1, 24'h000100, 16'h0, 0, 16'h0080, 16'h1111);
    chk("t1_latency", 32'(rsp_cyc - hs_cyc + 1), 14);
    chk("t1_data", 32'(got_data), 32'h0080);
    chk("t1_writes", 32'(wr_log.size()), 1);
    chk("t1_cmd", 32'(wr_log[0]), 32'h0070);

    run_op(2'd0, 24'h3F0000, 16'h0, 0, 16'h0080, 16'hA5C3);
    chk("t2_latency", 32'(rsp_cyc - hs_cyc + 1), 14);
    chk("t2_rsp", 32'({got_err, got_data}), 32'h0A5C3);
    chk("t2_cmd", 32'(wr_log[0]), 32'h00FF);

    run_op(2'd2, 24'h000010, 16'h1234, 3, 16'h0080, 16'h0);
    chk("t3_reads", 32'(rd_cnt), 4);
    chk("t3_nwrites", 32'(wr_log.size()), 4);
    chk("t3_w01", {wr_log[0], wr_log[1]}, 32'h0040_1234);
    chk("t3_w23", {wr_log[2], wr_log[3]}, 32'h0050_00FF);
    chk("t3_rsp", 32'({got_err, got_data}), 32'h00080);

    run_op(2'd2, 24'h000020, 16'hBEAD, 1, 16'h0090, 16'h0);
    chk("t4_err_sr", 32'({got_err, got_data}), 32'h10090);

    run_op(2'd2, 24'h000030, 16'h5555, 50, 16'h0080, 16'h0);
    chk("t4_timeout_reads", 32'(rd_cnt), PMAX);
    chk("t4_timeout_rsp", 32'({got_err, got_data}), 32'h10004);

    run_op(2'd3, 24'h020000, 16'h0, 0, 16'h0080, 16'h0);
    chk("t5_reads", 32'(rd_cnt), 0);
    chk("t5_writes", 32'(wr_log.size()), 2);
    chk("t5_cmds", {wr_log[0], wr_log[1]}, 32'h0060_00D0);
    chk("t5_data", 32'(got_data), 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      run_op(op, 24'($urandom), 16'($urandom), (op == 2'd2) ? int'($urandom_range(0, 9)) : 0,
             16'h0080 | 16'($urandom_range(0, 127)), 16'($urandom));
    end

    begin
      int b;
      build(2'd2, 24'h00ABCD, 16'h7777, 0, 16'h0080, 16'h0);
      issue(2'd2, 24'h00ABCD, 16'h7777);
      b = 50;
      while (nor_we_n !== 1'b0 && b > 0) begin
        @(negedge clk);
        b--;
      end
      chk("t6_reach_pulse", 32'(nor_we_n), 0);
      reset = 1'b1;
      chk_en = 1'b0;
      track = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("t6_abort", 32'({nor_ce_n, nor_we_n, nor_oe_n, nor_dq_oe, req_ready, rsp_valid}),
          32'(6'b111010));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
    end

    run_op(2'd1, 24'h000200, 16'h0, 0, 16'h0081, 16'h0);
    chk("t6_recover", 32'(got_data), 32'h0081);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
